// File: rtl/uart_tx_fifo_if.sv
// uart_tx_fifo_if: host write port, status flags and UART start/done link
// of the uart_tx_fifo byte buffer, bundled so the buffer and its
// environment share one set of signal names.
//
// Handshake semantics (host side): a byte is offered on wr_data whenever
// wr_en=1 and is accepted on that clock edge unless full=1, in which case it
// is dropped and overflow becomes sticky until clr_err.
// Handshake semantics (UART side): tx_start is a one-cycle pulse, tx_data is
// valid from that cycle and stays stable until the UART reports completion
// with a rising edge on tx_done; only rising edges count, so tx_done may be
// a level.
interface uart_tx_fifo_if #(
    parameter int DW = 8,
    parameter int AW = 4
);
    logic          wr_en;
    logic [DW-1:0] wr_data;
    logic          clr_err;
    logic          full;
    logic          empty;
    logic [AW:0]   count;
    logic          busy;
    logic          overflow;
    logic          tx_start;
    logic [DW-1:0] tx_data;
    logic          tx_done;
    logic [15:0]   bytes_sent;
    logic [1:0]    dbg_state;

    // Environment side: host writer plus the UART transmitter.
    modport master (
        output wr_en, wr_data, clr_err, tx_done,
        input  full, empty, count, busy, overflow,
               tx_start, tx_data, bytes_sent, dbg_state
    );

    // Buffer side.
    modport slave (
        input  wr_en, wr_data, clr_err, tx_done,
        output full, empty, count, busy, overflow,
               tx_start, tx_data, bytes_sent, dbg_state
    );
endinterface

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: DEPTH x DW byte buffer in front of a UART transmitter.
// The host writes at full clock rate; a three-state drain FSM hands bytes to
// the UART one at a time (start pulse, held data, wait for a done edge).
// Writes into a full buffer are dropped and raise a sticky overflow flag.
// Optional macro UART_TX_FIFO_STATS_EN builds a 16-bit completed-byte counter
// on bytes_sent; without it bytes_sent is tied to zero.
// dbg_state exposes the drain FSM state (0 IDLE, 1 START, 2 WAIT).
module uart_tx_fifo #(
    parameter int DEPTH = 16,   // power of two, at least 2
    parameter int AW    = 4,    // log2(DEPTH)
    parameter int DW    = 8
) (
    input  logic           clk,
    input  logic           rst,
    uart_tx_fifo_if.slave  bus
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_WAIT  = 2'd2
    } state_e;

    localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

    logic [DW-1:0] mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q;
    logic [AW:0]   count_q, count_d;
    logic          overflow_q, overflow_d;
    logic          done_q;
    state_e        state_q;
    logic          tx_start_q;
    logic [DW-1:0] tx_data_q;
    logic [15:0]   bytes_sent_q;

    logic full, empty, push, drop, pop, done_pulse, complete;

    // Flags come from the registered count, so a write that meets a full
    // buffer is dropped even if the FSM pops in the same cycle.
    assign full       = (count_q == DEPTH_C);
    assign empty      = (count_q == '0);
    assign push       = bus.wr_en && !full;
    assign drop       = bus.wr_en && full;
    assign pop        = (state_q == S_IDLE) && !empty;
    assign done_pulse = bus.tx_done & ~done_q;
    // Only an edge seen while waiting finishes a byte; edges in IDLE/START
    // are ignored and a level already high on entry to WAIT needs a new edge.
    assign complete   = (state_q == S_WAIT) && done_pulse;

    // Next write pointer, occupancy and sticky overflow (a drop beats clr_err).
    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        count_d    = count_q;
        overflow_d = overflow_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        case ({push, pop})
            2'b10:   count_d = count_q + (AW+1)'(1);
            2'b01:   count_d = count_q - (AW+1)'(1);
            default: count_d = count_q;
        endcase
        if (bus.clr_err) begin
            overflow_d = 1'b0;
        end
        if (drop) begin
            overflow_d = 1'b1;
        end
    end

    // Write-side bookkeeping and the tx_done edge detector register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
            done_q     <= bus.tx_done;
        end
    end

    // Byte storage; contents need no reset because the pointers gate reads.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= bus.wr_data;
        end
    end

    // Drain FSM with registered tx_start/tx_data; the byte is taken out of
    // the buffer in IDLE so count excludes the byte in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            rd_ptr_q   <= '0;
            tx_start_q <= 1'b0;
            tx_data_q  <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (pop) begin
                        tx_data_q  <= mem_q[rd_ptr_q];
                        rd_ptr_q   <= rd_ptr_q + AW'(1);
                        tx_start_q <= 1'b1;
                        state_q    <= S_START;
                    end
                end
                S_START: begin
                    tx_start_q <= 1'b0;
                    state_q    <= S_WAIT;
                end
                S_WAIT: begin
                    if (complete) begin
                        state_q <= S_IDLE;
                    end
                end
                default: begin
                    tx_start_q <= 1'b0;
                    state_q    <= S_IDLE;
                end
            endcase
        end
    end

`ifdef UART_TX_FIFO_STATS_EN
    // Completed-byte counter, wraps naturally at 16 bits.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bytes_sent_q <= '0;
        end else if (complete) begin
            bytes_sent_q <= bytes_sent_q + 16'd1;
        end
    end
`else
    assign bytes_sent_q = '0;
`endif

    assign bus.full       = full;
    assign bus.empty      = empty;
    assign bus.count      = count_q;
    assign bus.busy       = (state_q != S_IDLE);
    assign bus.overflow   = overflow_q;
    assign bus.tx_start   = tx_start_q;
    assign bus.tx_data    = tx_data_q;
    assign bus.bytes_sent = bytes_sent_q;
    assign bus.dbg_state  = state_q;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb_uart_tx_fifo: randomized bench for uart_tx_fifo. A queue-based model
// predicts occupancy, flags and the byte in flight each cycle; an expected
// queue of accepted bytes checks the order in which bytes reach the UART.
module tb_uart_tx_fifo;

    localparam int DEPTH = 16;
    localparam int AW    = 4;
    localparam int DW    = 8;

    localparam int DM_AUTO   = 0;  // responder pulses tx_done after a delay
    localparam int DM_STALL  = 1;  // tx_done forced low
    localparam int DM_HIGH   = 2;  // tx_done forced high
    localparam int DM_MANUAL = 3;  // sequence drives tx_done directly

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    uart_tx_fifo_if #(.DW(DW), .AW(AW)) bus ();

    uart_tx_fifo #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // ---------------- reference model / scoreboard ----------------
    logic [DW-1:0] m_q[$];      // bytes stored in the buffer
    logic [DW-1:0] exp_q[$];    // accepted bytes, in the order they must leave
    logic [DW-1:0] tx_log[$];   // bytes seen at each tx_start
    int            m_phase;     // 0 free, 1 start cycle, 2 waiting for done
    logic [DW-1:0] m_cur;
    bit            m_ovf;
    bit            m_done_prev;
    int            m_sent;

    int n_checks = 0;
    int n_errors = 0;
    int done_mode = DM_AUTO;
    int hi_left = 0;
    int wait_left = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic void model_reset();
        m_q.delete();
        exp_q.delete();
        m_phase     = 0;
        m_cur       = '0;
        m_ovf       = 1'b0;
        m_done_prev = 1'b0;
        m_sent      = 0;
        hi_left     = 0;
        wait_left   = 0;
    endfunction

    // Advance the model by one clock using the inputs presented this cycle.
    function automatic void model_step();
        bit full_m;
        bit pulse;
        full_m = (m_q.size() == DEPTH);
        pulse  = bus.tx_done && !m_done_prev;
        if (m_phase == 0) begin
            if (m_q.size() > 0) begin
                m_cur   = m_q.pop_front();
                m_phase = 1;
            end
        end else if (m_phase == 1) begin
            m_phase = 2;
        end else if (pulse) begin
            m_phase = 0;
            m_sent++;
        end
        if (bus.clr_err) m_ovf = 1'b0;
        if (bus.wr_en) begin
            if (full_m) begin
                m_ovf = 1'b1;
            end else begin
                m_q.push_back(bus.wr_data);
                exp_q.push_back(bus.wr_data);
            end
        end
        m_done_prev = bus.tx_done;
    endfunction

    task automatic check_outputs();
        check("count", bus.count, m_q.size());
        check("empty", bus.empty, m_q.size() == 0);
        check("full", bus.full, m_q.size() == DEPTH);
        check("overflow", bus.overflow, m_ovf);
        check("busy", bus.busy, m_phase != 0);
        check("tx_start", bus.tx_start, m_phase == 1);
        if (m_phase != 0) check("tx_data_hold", bus.tx_data, m_cur);
`ifdef UART_TX_FIFO_STATS_EN
        check("bytes_sent", bus.bytes_sent, m_sent & 32'hFFFF);
`else
        check("bytes_sent", bus.bytes_sent, 0);
`endif
        if (bus.tx_start) begin
            tx_log.push_back(bus.tx_data);
            check("sb_nonempty", exp_q.size() > 0, 1);
            if (exp_q.size() > 0) check("sb_order", bus.tx_data, exp_q.pop_front());
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic drive_done();
        case (done_mode)
            DM_STALL: bus.tx_done = 1'b0;
            DM_HIGH:  bus.tx_done = 1'b1;
            DM_AUTO: begin
                if (bus.tx_done) begin
                    if (hi_left > 0) hi_left--;
                    if (hi_left == 0) bus.tx_done = 1'b0;
                end else if (m_phase == 2) begin
                    if (wait_left == 0) begin
                        bus.tx_done = 1'b1;
                        hi_left     = $urandom_range(1, 3);
                        wait_left   = $urandom_range(0, 3);
                    end else begin
                        wait_left--;
                    end
                end
            end
            default: ;
        endcase
    endtask

    // One clock: inputs were set after the previous falling edge.
    task automatic tick();
        drive_done();
        @(posedge clk);
        model_step();
        @(negedge clk);
        check_outputs();
    endtask

    task automatic write_byte(input logic [DW-1:0] b);
        bus.wr_en   = 1'b1;
        bus.wr_data = b;
        tick();
        bus.wr_en   = 1'b0;
    endtask

    task automatic drain(input int budget);
        int n;
        n = 0;
        done_mode = DM_AUTO;
        while (!(m_phase == 0 && m_q.size() == 0) && n < budget) begin
            tick();
            n++;
        end
        check("drain_in_budget", n < budget, 1);
    endtask

    // Reset asserted between edges; outputs must clear without a clock.
    task automatic do_reset();
        bus.wr_en   = 1'b0;
        bus.clr_err = 1'b0;
        bus.tx_done = 1'b0;
        done_mode   = DM_AUTO;
        #2 rst = 1'b1;
        #1;
        check("rst_tx_start", bus.tx_start, 0);
        check("rst_count", bus.count, 0);
        check("rst_empty", bus.empty, 1);
        check("rst_overflow", bus.overflow, 0);
        check("rst_busy", bus.busy, 0);
        model_reset();
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check("rst_tx_data", bus.tx_data, 0);
        check_outputs();
    endtask

    // Watchdog so a stuck run still reports.
    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus ----------------
    initial begin
        bus.wr_en   = 1'b0;
        bus.wr_data = '0;
        bus.clr_err = 1'b0;
        bus.tx_done = 1'b0;
        model_reset();
        @(negedge clk);
        do_reset();

        // Single byte latency and hold.
        tx_log.delete();
        done_mode = DM_STALL;
        write_byte(8'hA5);
        check("lat_c1_count", bus.count, 1);
        check("lat_c1_empty", bus.empty, 0);
        tick();
        check("lat_c2_start", bus.tx_start, 1);
        check("lat_c2_data", bus.tx_data, 8'hA5);
        check("lat_c2_count", bus.count, 0);
        repeat (4) tick();
        check("hold_data", bus.tx_data, 8'hA5);
        check("hold_busy", bus.busy, 1);
        done_mode = DM_MANUAL;
        bus.tx_done = 1'b1;
        tick();
        check("done_busy_low", bus.busy, 0);
        bus.tx_done = 1'b0;
        tick();

        // Burst into a stalled UART: fill, overflow, clear, release.
        tx_log.delete();
        done_mode = DM_STALL;
        for (int i = 1; i <= 17; i++) write_byte(DW'(i));
        check("burst_full", bus.full, 1);
        check("burst_count", bus.count, DEPTH);
        write_byte(8'hFF);
        check("burst_overflow", bus.overflow, 1);
        check("burst_count_kept", bus.count, DEPTH);
        bus.clr_err = 1'b1;
        tick();
        check("clr_err", bus.overflow, 0);
        bus.wr_en = 1'b1;
        bus.wr_data = 8'hFF;
        tick();
        check("clr_vs_drop", bus.overflow, 1);
        bus.wr_en = 1'b0;
        tick();
        bus.clr_err = 1'b0;
        check("clr_err_again", bus.overflow, 0);
        drain(1000);
        check("burst_len", tx_log.size(), 17);
        for (int i = 0; i < 17 && i < tx_log.size(); i++) check("burst_order", tx_log[i], i + 1);

        // Push and pop in the same cycle keep count.
        done_mode = DM_STALL;
        for (int i = 0; i < 4; i++) write_byte(8'h40 + DW'(i));
        check("pp_count_before", bus.count, 3);
        done_mode = DM_MANUAL;
        bus.tx_done = 1'b1;
        tick();
        check("pp_idle", bus.busy, 0);
        write_byte(8'h77);
        check("pp_count_after", bus.count, 3);
        bus.tx_done = 1'b0;
        drain(1000);

        // Random traffic with wrap, overflow and clears.
        done_mode = DM_AUTO;
        for (int i = 0; i < 300; i++) begin
            bus.wr_en   = ($urandom_range(0, 99) < 55);
            bus.wr_data = DW'($urandom);
            bus.clr_err = ($urandom_range(0, 19) == 0);
            tick();
        end
        bus.wr_en   = 1'b0;
        bus.clr_err = 1'b0;
        drain(2000);

        // Level-held done: second byte needs a fresh rising edge.
        tx_log.delete();
        done_mode = DM_MANUAL;
        bus.tx_done = 1'b0;
        write_byte(8'h5A);
        write_byte(8'hC3);
        repeat (3) tick();
        bus.tx_done = 1'b1;
        repeat (10) tick();
        check("level_busy", bus.busy, 1);
        check("level_starts", tx_log.size(), 2);
        bus.tx_done = 1'b0;
        tick();
        bus.tx_done = 1'b1;
        tick();
        check("level_done", bus.busy, 0);
        bus.tx_done = 1'b0;
        tick();
        check("level_starts_end", tx_log.size(), 2);

        // Reset while waiting on the UART with bytes queued.
        done_mode = DM_STALL;
        for (int i = 0; i < 5; i++) write_byte(DW'($urandom));
        repeat (3) tick();
        check("mid_wait_busy", bus.busy, 1);
        do_reset();
        tx_log.delete();
        write_byte(8'h3C);
        drain(1000);
        check("post_rst_len", tx_log.size(), 1);
        if (tx_log.size() > 0) check("post_rst_byte", tx_log[0], 8'h3C);

        // Ten transfers from a clean reset for the byte counter.
        do_reset();
        for (int i = 0; i < 10; i++) begin
            write_byte(DW'($urandom));
            repeat ($urandom_range(0, 6)) tick();
        end
        drain(2000);
`ifdef UART_TX_FIFO_STATS_EN
        check("stats_ten", bus.bytes_sent, 10);
`else
        check("stats_off", bus.bytes_sent, 0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
